// File: rtl/vie_inst_ram.sv
// vie_inst_ram: instruction SRAM responder with one-cycle fetch reads and a streaming program loader.
// The loader owns the array while LOAD/DONE; the fetch port is live in IDLE and ERR.
module vie_inst_ram #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'hbfc00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [68:0] inst_ifc_i,
    output logic [31:0] ifc_inst_o,
    input  logic        ld_start,
    input  logic [31:0] ld_base,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         mem [2**ADDR_W];

    logic                f_en;
    logic [3:0]          f_wen;
    logic [31:0]         f_addr, f_wdata;
    logic                f_hit, l_hit, fetch_ok, l_acc;
    logic [ADDR_W-1:0]   f_idx, l_idx, mem_idx;
    logic [3:0]          mem_we;
    logic [31:0]         mem_wd;
    logic                unused_ok;

    assign {f_en, f_wen, f_addr, f_wdata} = inst_ifc_i;
    assign f_hit     = f_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2];
    assign l_hit     = ld_base[31:ADDR_W+2] == BASE[31:ADDR_W+2];
    assign f_idx     = f_addr[ADDR_W+1:2];
    assign l_idx     = ld_base[ADDR_W+1:2];
    assign unused_ok = ^{f_addr[1:0], ld_base[1:0]};
    assign fetch_ok  = state_q == S_IDLE || state_q == S_ERR;
    assign l_acc     = state_q == S_LOAD && ld_valid;

    // Loader and fetch writes are mutually exclusive by state, so one write port suffices.
    assign mem_we  = l_acc ? 4'hf : ((f_en && fetch_ok && f_hit) ? f_wen : 4'h0);
    assign mem_idx = l_acc ? cnt_q : f_idx;
    assign mem_wd  = l_acc ? ld_data : f_wdata;
    assign rdata_d = (f_en && f_wen == 4'h0) ? ((fetch_ok && f_hit) ? mem[f_idx] : 32'h0) : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR: if (ld_start) begin
                state_d = l_hit ? S_LOAD : S_ERR;
                cnt_d   = l_hit ? l_idx : cnt_q;
            end
            S_LOAD: if (ld_valid) begin
                state_d = ld_last ? S_DONE : (&cnt_q ? S_ERR : S_LOAD);
                cnt_d   = cnt_q + ADDR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // The array is never reset so a preloaded image survives a CPU reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_idx][i*8 +: 8] <= mem_wd[i*8 +: 8];
    end

    assign ifc_inst_o = rdata_q;
    assign ld_ready   = state_q == S_LOAD;
    assign ld_busy    = state_q == S_LOAD || state_q == S_DONE;
    assign ld_done    = state_q == S_DONE;
    assign ld_err     = state_q == S_ERR;
endmodule

// File: tb/tb_vie_inst_ram.sv
// tb_vie_inst_ram: directed stimulus for vie_inst_ram, checked every cycle against a word-level memory model.
module tb_vie_inst_ram;
    localparam logic [31:0] BASE = 32'hbfc00000;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

    logic clock = 0, reset = 1;
    always #5 clock = ~clock;

    logic        en = 0;
    logic [3:0]  wen = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        ld_start = 0, ld_valid = 0, ld_last = 0;
    logic [31:0] ld_base = 0, ld_data = 0;
    logic [31:0] ifc_inst_o;
    logic        ld_ready, ld_busy, ld_done, ld_err;

    vie_inst_ram dut (
        .clock(clock), .reset(reset), .inst_ifc_i({en, wen, addr, wdata}), .ifc_inst_o(ifc_inst_o),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [31:0] a);
        logic [31:0] b;
        b = BASE;
        return a[31:14] == b[31:14];
    endfunction

    function automatic logic [31:0] wa(input int i);
        return BASE + 32'(4 * i);
    endfunction

    // Model: word-level memory with per-word "known" flags, loader mode, expected read data.
    int          m_mode;
    logic [11:0] m_cnt;
    logic [31:0] mm [4096];
    bit          kn [4096];
    logic [31:0] m_rd;
    bit          m_rdk, m_fe;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_rd   = 0;
            m_rdk  = 1;
        end else begin
            m_fe = m_mode == M_IDLE || m_mode == M_ERR;
            if (en && wen == 4'h0) begin
                if (m_fe && hit(addr)) begin
                    m_rd  = mm[addr[13:2]];
                    m_rdk = kn[addr[13:2]];
                end else begin
                    m_rd  = 0;
                    m_rdk = 1;
                end
            end else if (en && m_fe && hit(addr)) begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) mm[addr[13:2]][8*b +: 8] = wdata[8*b +: 8];
                kn[addr[13:2]] = kn[addr[13:2]] || wen == 4'hf;
            end
            case (m_mode)
                M_IDLE, M_ERR: if (ld_start) begin
                    if (hit(ld_base)) begin
                        m_mode = M_LOAD;
                        m_cnt  = ld_base[13:2];
                    end else m_mode = M_ERR;
                end
                M_LOAD: if (ld_valid) begin
                    mm[m_cnt] = ld_data;
                    kn[m_cnt] = 1;
                    if (ld_last) m_mode = M_DONE;
                    else if (m_cnt == 12'd4095) m_mode = M_ERR;
                    else m_cnt = m_cnt + 1;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("m_ready", ld_ready, m_mode == M_LOAD);
            check("m_busy", ld_busy, m_mode == M_LOAD || m_mode == M_DONE);
            check("m_done", ld_done, m_mode == M_DONE);
            check("m_err", ld_err, m_mode == M_ERR);
            if (m_rdk) check("m_rdata", ifc_inst_o, m_rd);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        en = 1; wen = 0; addr = a;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        en = 1; wen = w; addr = a; wdata = d;
    endtask

    task automatic fidle();
        en = 0; wen = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(); cyc();
        check("rst_rdata", ifc_inst_o, 32'h0);
        check("rst_busy", ld_busy, 1'b0);
        check("rst_err", ld_err, 1'b0);
        reset = 0;
        wr(wa(0), 4'hf, 32'hdeadbeef); cyc();
        rd(wa(0)); cyc();
        check("rd_word0", ifc_inst_o, 32'hdeadbeef);
        fidle();
        ld_start = 1; ld_base = wa(0); cyc();
        check("ready_after_start", ld_ready, 1'b1);
        ld_start = 0; ld_valid = 1;
        for (int k = 0; k < 4; k++) begin
            ld_data = 32'h24010001 + 32'(k);
            ld_last = k == 3;
            cyc();
        end
        check("done_pulse", ld_done, 1'b1);
        ld_valid = 0; ld_last = 0; cyc();
        check("done_cleared", ld_done, 1'b0);
        rd(wa(0)); cyc();
        for (int k = 1; k < 4; k++) begin
            check("fetch_seq", ifc_inst_o, 32'h24010000 + 32'(k));
            rd(wa(k)); cyc();
        end
        check("fetch_last", ifc_inst_o, 32'h24010004);
        fidle(); cyc();
        check("hold_en0", ifc_inst_o, 32'h24010004);
        ld_start = 1; ld_base = 32'h80000000; cyc();
        ld_start = 0;
        check("miss_err", ld_err, 1'b1);
        check("miss_busy", ld_busy, 1'b0);
        rd(32'h80000000); cyc();
        check("fetch_miss", ifc_inst_o, 32'h0);
        rd(wa(0)); cyc();
        check("err_fetch", ifc_inst_o, 32'h24010001);
        fidle();
        ld_start = 1; ld_base = wa(8); cyc();
        ld_start = 0;
        check("err_cleared", ld_err, 1'b0);
        rd(wa(0)); ld_valid = 1; ld_last = 1; ld_data = 32'h00000055; cyc();
        check("fetch_in_load", ifc_inst_o, 32'h0);
        fidle(); ld_valid = 0; ld_last = 0; cyc();
        ld_start = 1; ld_base = wa(4094); cyc();
        ld_start = 0; ld_valid = 1; ld_data = 32'ha1a1a1a1; cyc();
        ld_data = 32'ha2a2a2a2; cyc();
        check("ovf_ready", ld_ready, 1'b0);
        check("ovf_err", ld_err, 1'b1);
        ld_data = 32'ha3a3a3a3; cyc();
        ld_valid = 0;
        check("ovf_err_hold", ld_err, 1'b1);
        rd(wa(4094)); cyc();
        check("ovf_w4094", ifc_inst_o, 32'ha1a1a1a1);
        rd(wa(4095)); cyc();
        check("ovf_w4095", ifc_inst_o, 32'ha2a2a2a2);
        rd(wa(0)); cyc();
        check("ovf_no_wrap", ifc_inst_o, 32'h24010001);
        fidle();
        ld_start = 1; ld_base = wa(4094); cyc();
        ld_start = 0;
        check("ovf2_err_clr", ld_err, 1'b0);
        ld_valid = 1; ld_data = 32'hb1b1b1b1; cyc();
        ld_data = 32'hb2b2b2b2; ld_last = 1; cyc();
        check("ovf2_done", ld_done, 1'b1);
        check("ovf2_no_err", ld_err, 1'b0);
        ld_valid = 0; ld_last = 0; cyc();
        check("ovf2_idle", ld_busy, 1'b0);
        rd(wa(4095)); cyc();
        check("ovf2_w4095", ifc_inst_o, 32'hb2b2b2b2);
        wr(wa(1), 4'hf, 32'h11223344); cyc();
        rd(wa(2)); cyc();
        check("pre_byte", ifc_inst_o, 32'h24010003);
        wr(wa(1), 4'b0101, 32'haabbccdd); cyc();
        check("byte_hold", ifc_inst_o, 32'h24010003);
        rd(wa(1)); cyc();
        check("byte_merge", ifc_inst_o, 32'h11bb33dd);
        wr(wa(18), 4'hf, 32'hcafef00d); cyc();
        rd(wa(18)); cyc();
        check("pre_w18", ifc_inst_o, 32'hcafef00d);
        fidle();
        ld_start = 1; ld_base = wa(16); cyc();
        ld_start = 0; ld_valid = 1; ld_data = 32'hc0c0c0c0; cyc();
        ld_data = 32'hc1c1c1c1; cyc();
        check("midload_busy", ld_busy, 1'b1);
        ld_data = 32'hc2c2c2c2;
        #2 reset = 1;
        #1;
        check("async_rdata", ifc_inst_o, 32'h0);
        check("async_busy", ld_busy, 1'b0);
        check("async_ready", ld_ready, 1'b0);
        ld_valid = 0; cyc();
        reset = 0;
        rd(wa(16)); cyc();
        check("keep_w16", ifc_inst_o, 32'hc0c0c0c0);
        rd(wa(17)); cyc();
        check("keep_w17", ifc_inst_o, 32'hc1c1c1c1);
        rd(wa(18)); cyc();
        check("keep_w18", ifc_inst_o, 32'hcafef00d);
        fidle(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vie_inst_ram.md
# vie_inst_ram

Instruction-side SRAM responder: the slave end of the fetch stage's `inst_sram` request bus. It serves one fetch per cycle with fixed one-cycle read latency. It also provides a streaming loader port that preloads program images into the array before the CPU is released from reset. It sits between the fetch stage and the instruction memory array at the top of the CPU subsystem.

## Interface
- `ADDR_W`, default 12: word-address width; depth is 2^ADDR_W words (4096 words = 16 KB).
- `BASE`, default 32'hbfc00000: byte base address of the window; it must be aligned to 2^(ADDR_W+2).
- `clock`  in  1  system clock; the block has one clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `inst_ifc_i`  in  `Vtoifcbus` (69)  fetch request:
  - [68] en
  - [67:64] wen
  - [63:32] addr
  - [31:0] wdata
- `ifc_inst_o`  out  `Vfromifcbus` (32)  read data returned to the fetch stage.
- `ld_start`  in  1  pulse that begins a load.
- `ld_base`  in  32  byte address of the first loaded word.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  32  loader word.
- `ld_last`  in  1  marks the final word; qualified by `ld_valid`.
- `ld_ready`  out  1  block accepts a loader word.
- `ld_busy`  out  1  FSM is in LOAD or DONE.
- `ld_done`  out  1  one-cycle pulse on successful completion.
- `ld_err`  out  1  sticky load error.

## Operation
- **Address decode.**
  - hit = (addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]).
  - index = addr[ADDR_W+1:2].
  - addr[1:0] is ignored; the fetch stage raises ADEL itself.
- **Fetch read** (en=1, wen=0, FSM IDLE or ERR):
  - The array is read at the index.
  - ifc_inst_o = mem[index] on a hit, 32'h0 on a miss.
- **Fetch write** (en=1, wen≠0, hit, FSM IDLE or ERR): byte-merge; wen[i] writes byte i. ifc_inst_o holds its previous value.
- **Fetch write miss:** dropped silently.
- **en=0:** ifc_inst_o holds its last value (SRAM output-latch semantics).
- **Fetch during LOAD or DONE:** reads return 32'h0 and writes are dropped. The system holds the CPU in reset while loading.
- **Loader FSM.** States: IDLE, LOAD, DONE, ERR.
  - IDLE or ERR, `ld_start`=1:
    - If `ld_base` hits: counter ← index(`ld_base`), `ld_err` ← 0, go to LOAD.
    - Otherwise: `ld_err` ← 1, go to ERR.
  - LOAD: `ld_ready`=1. Each `ld_valid`&&`ld_ready` writes `ld_data` to mem[counter] and then:
    - `ld_last`=1 → DONE.
    - otherwise, counter = 2^ADDR_W−1 → ERR (overflow; the word is still written).
    - otherwise → counter+1, stay in LOAD.
  - LOAD, `ld_start`=1: ignored.
  - DONE: `ld_done`=1 for exactly one cycle, then IDLE.
  - ERR: `ld_err`=1 until the next accepted `ld_start`. The fetch port operates normally in ERR.
- **Outputs per state.**
  - `ld_busy`=1 in LOAD and DONE.
  - `ld_ready`=1 only in LOAD.
  - `ld_err`=1 only in ERR.
- **Simultaneous events:**
  - `ld_valid` together with `ld_last` on the overflow word → DONE; `ld_last` takes priority.
  - Fetch request and loader write in the same cycle: the loader wins and the fetch read returns 0.
- **Reset** (asynchronous, any time including mid-load):
  - FSM → IDLE, counter → 0, ifc_inst_o → 32'h0, `ld_err` → 0.
  - `ld_ready`/`ld_busy`/`ld_done` are 0.
  - Array contents are not cleared; words already loaded remain.

## Timing
- Read latency: exactly 1 cycle. A request sampled at edge N drives ifc_inst_o from edge N until edge N+1; it holds beyond that while en=0.
- Back-to-back fetches: one per cycle, no bubbles, no stall path. The fetch stage has no wait signal.
- Write-then-read of the same word on consecutive cycles returns the new data (write-first across cycles).
- `ld_ready`, `ld_busy`, `ld_err` and `ld_done` are registered-state decodes with no combinational path from `ld_valid`.
- `ld_start` sampled at edge N → `ld_ready`=1 from edge N; the first word can be accepted at edge N+1.
- A load of K words with `ld_valid` held high takes K cycles in LOAD plus 1 cycle in DONE.

## Test plan
- **Reset/default read.**
  - Reset is asserted mid-cycle (asynchronous): ifc_inst_o=0 and `ld_busy`=0 with no clock edge.
  - Fetch en at addr 32'hbfc00000 after reset returns mem[0].
- **Load and fetch.**
  - `ld_start` with `ld_base`=32'hbfc00000, then 4 words 32'h24010001..04, `ld_last` on the 4th: `ld_done` pulses once.
  - Fetches at bfc00000, bfc00004, bfc00008, bfc0000c on consecutive cycles return those words one cycle later.
- **Miss/error.**
  - `ld_base`=32'h80000000 → `ld_err`=1, FSM in ERR, no write.
  - Fetch at 32'h80000000 → 32'h0.
  - A subsequent valid `ld_start` clears `ld_err`.
- **Overflow.**
  - Load starting at index 4094 with 3 words and no `ld_last` → words land at 4094 and 4095, then ERR.
  - The third word is not accepted (`ld_ready`=0).
  - Repeat with `ld_last` on the 4095 word → DONE, no error.
- **Byte write.**
  - mem[1]=32'h11223344; fetch write wen=4'b0101, wdata=32'hAABBCCDD.
  - A read next cycle returns 32'h11BB33DD; ifc_inst_o held its old value during the write cycle.
- **Reset mid-load.**
  - Reset after 2 of 5 words → FSM IDLE, `ld_busy`=0.
  - Reads of words 0–1 return the loaded data; word 2 keeps its prior contents.
